vdp_vram_arb: RTL and testbench
===============================

Name: vdp_vram_arb

Overview:
- Shares the single-port 16KiB VRAM between the display-fetch DMA reads and the CPU data-port traffic.
- CPU traffic follows TMS9918 semantics:
  - address load, with or without read-ahead;
  - auto-incrementing data reads and writes;
  - a one-byte read-ahead buffer.
- Display DMA has absolute priority. CPU operations complete in the free ring-counter slots.
- Sits between the VDP fetch FSM, the CPU port decoder (ticks already synchronised to pxclk) and the VRAM.

Parameters:
- ADDR_W, 14, VRAM address width.
- WAIT_W, 8, width of the CPU wait counter and max-wait statistic (saturating).

Ports:
- pxclk  input  1  pixel clock, 25MHz.
- reset  input  1  synchronous, active-high.
- dma_addr  input  ADDR_W  display-fetch read address (registered upstream).
- dma_rd_tick  input  1  display-fetch read request this cycle.
- cpu_addr  input  ADDR_W  new CPU VRAM address.
- cpu_addr_tick  input  1  load cpu_addr.
- cpu_addr_rd  input  1  with cpu_addr_tick: 1 = schedule a read-ahead.
- cpu_wr_tick  input  1  CPU data-port write.
- cpu_wr_data  input  8  byte to write.
- cpu_rd_tick  input  1  CPU data-port read; consumes cpu_rd_data.
- cpu_rd_data  output  8  read-ahead buffer.
- cpu_busy  output  1  CPU operation pending or in flight.
- cpu_overrun  output  1  sticky: a CPU tick arrived while busy.
- cpu_overrun_clr  input  1  clears cpu_overrun.
- cpu_wait_max  output  WAIT_W  longest CPU wait (cycles), saturating.
- vram_addr  output  ADDR_W  VRAM address.
- vram_wr  output  1  VRAM write strobe.
- vram_din  output  8  VRAM write data.
- vram_dout  input  8  VRAM read data, valid one cycle after the read address.

Behaviour:
- Clocking: reset is synchronous and active-high; the clock is pxclk.

Reset values:
- State is IDLE. cpu_addr_reg, rd_buf and wr_buf are 0.
- cpu_busy, cpu_overrun and cpu_wait_max are 0.
- vram_wr is 0.

VRAM mux (combinational from registered state):
- If dma_rd_tick = 1: vram_addr = dma_addr, vram_wr = 0.
- Else if state is PEND_RD or PEND_WR: vram_addr = cpu_addr_reg, vram_wr = (state == PEND_WR).
- Else vram_addr = cpu_addr_reg, vram_wr = 0.
- vram_din = wr_buf at all times.

FSM states:
- IDLE:
  - cpu_addr_tick: cpu_addr_reg <= cpu_addr. If cpu_addr_rd, go to PEND_RD; else stay IDLE.
  - cpu_wr_tick: wr_buf <= cpu_wr_data; go to PEND_WR.
  - cpu_rd_tick: cpu_rd_data is already valid; go to PEND_RD to refill.
  - Priority if several ticks arrive in one cycle: addr > wr > rd. The lower-priority ticks are dropped and cpu_overrun is set.
- PEND_RD:
  - If dma_rd_tick = 0, the read issues this cycle; go to RD_CAP.
  - Otherwise hold PEND_RD.
- RD_CAP:
  - rd_buf <= vram_dout.
  - cpu_addr_reg <= cpu_addr_reg + 1 (wraps 3FFF -> 0000).
  - Go to IDLE.
- PEND_WR:
  - If dma_rd_tick = 0, the write issues this cycle.
  - Also rd_buf <= wr_buf (TMS9918 write-through) and cpu_addr_reg <= cpu_addr_reg + 1 (wraps).
  - Go to IDLE.
  - Otherwise hold PEND_WR.

Busy and overrun:
- cpu_busy = (state != IDLE).
- Any CPU tick while busy is ignored and sets cpu_overrun.
- Exception: cpu_addr_tick while busy aborts the pending op. It is accepted as if in IDLE and still sets cpu_overrun.
- cpu_overrun_clr and a set in the same cycle: set wins.

Wait statistic:
- wait_ctr counts cycles spent in PEND_RD or PEND_WR and resets on entry to either state.
- On issue, cpu_wait_max <= max(cpu_wait_max, wait_ctr). Both saturate at all-ones.

Timing:
- Nominal latency from tick to issue is 1 cycle when no DMA is present.
- Reset mid-operation abandons the pending op with no write issued.
- A DMA tick arriving in the same cycle as a pending CPU op always wins.

Decomposition:
- Shared package vdp_pkg holds:
  - ARB_IDLE, ARB_PEND_RD, ARB_RD_CAP, ARB_PEND_WR state encodings (2-bit);
  - VRAM_ADDR_W = 14;
  - VRAM_DATA_W = 8.
- No sub-module is needed. The saturating max-tracker is small enough to stay inline.

Test Plan:
- Load addr 0x1234 with rd, VRAM[0x1234] = 0xA5, no DMA -> PEND_RD issues at cycle 1; cpu_rd_data = 0xA5 at cycle 3; cpu_addr_reg = 0x1235; cpu_busy low at cycle 3.
- Write 0x5A at addr 0x3FFF, no DMA -> VRAM[0x3FFF] = 0x5A; cpu_rd_data = 0x5A; cpu_addr_reg wraps to 0x0000.
- dma_rd_tick held high 5 cycles during PEND_WR -> vram_addr follows dma_addr, vram_wr = 0 throughout; write issues on cycle 6; cpu_wait_max = 5.
- cpu_wr_tick while PEND_RD -> tick ignored, cpu_overrun = 1 and stays until cpu_overrun_clr; the read still completes correctly.
- Ring pattern: DMA ticks in slots 0, 2, 3 of 8, with 16 back-to-back CPU writes -> all 16 bytes land at sequential addresses; no DMA read is delayed; vram_wr is never asserted with dma_rd_tick.
- Reset asserted in PEND_WR -> no vram_wr pulse; all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM geometry and the VRAM arbiter state encoding.
package vdp_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_PEND_RD = 2'd1,
        ARB_RD_CAP  = 2'd2,
        ARB_PEND_WR = 2'd3
    } arb_state_t;

endpackage

// File: rtl/vdp_vram_arb_if.sv
// VRAM arbiter bus: display-fetch DMA, CPU data port and the VRAM side in one bundle.
interface vdp_vram_arb_if
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int WAIT_W = 8
);
    logic [ADDR_W-1:0]      dma_addr;
    logic                   dma_rd_tick;
    logic [ADDR_W-1:0]      cpu_addr;
    logic                   cpu_addr_tick;
    logic                   cpu_addr_rd;
    logic                   cpu_wr_tick;
    logic [VRAM_DATA_W-1:0] cpu_wr_data;
    logic                   cpu_rd_tick;
    logic [VRAM_DATA_W-1:0] cpu_rd_data;
    logic                   cpu_busy;
    logic                   cpu_overrun;
    logic                   cpu_overrun_clr;
    logic [WAIT_W-1:0]      cpu_wait_max;
    logic [ADDR_W-1:0]      vram_addr;
    logic                   vram_wr;
    logic [VRAM_DATA_W-1:0] vram_din;
    logic [VRAM_DATA_W-1:0] vram_dout;

    modport master (
        output dma_addr, dma_rd_tick, cpu_addr, cpu_addr_tick, cpu_addr_rd,
               cpu_wr_tick, cpu_wr_data, cpu_rd_tick, cpu_overrun_clr, vram_dout,
        input  cpu_rd_data, cpu_busy, cpu_overrun, cpu_wait_max,
               vram_addr, vram_wr, vram_din
    );

    modport slave (
        input  dma_addr, dma_rd_tick, cpu_addr, cpu_addr_tick, cpu_addr_rd,
               cpu_wr_tick, cpu_wr_data, cpu_rd_tick, cpu_overrun_clr, vram_dout,
        output cpu_rd_data, cpu_busy, cpu_overrun, cpu_wait_max,
               vram_addr, vram_wr, vram_din
    );

endinterface

// File: rtl/vdp_vram_arb.sv
// Single-port VRAM arbiter: display DMA reads always win, TMS9918-style CPU
// data-port reads/writes fill the remaining cycles.
module vdp_vram_arb
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int WAIT_W = 8
)(
    input  logic                 pxclk,
    input  logic                 reset,
    vdp_vram_arb_if.slave        bus
);

    arb_state_t             state;
    logic [ADDR_W-1:0]      cpu_addr_reg;
    logic [VRAM_DATA_W-1:0] rd_buf;
    logic [VRAM_DATA_W-1:0] wr_buf;
    logic                   overrun;
    logic [WAIT_W-1:0]      wait_ctr;
    logic [WAIT_W-1:0]      wait_max;

    logic busy;
    logic pend;
    logic issue;
    logic ovr_set;

    assign busy  = (state != ARB_IDLE);
    assign pend  = (state == ARB_PEND_RD) || (state == ARB_PEND_WR);
    assign issue = pend && !bus.dma_rd_tick;

    // Dropped ticks: anything while busy, or lower-priority ticks colliding in IDLE.
    assign ovr_set = (busy && (bus.cpu_addr_tick || bus.cpu_wr_tick || bus.cpu_rd_tick))
                   || (bus.cpu_addr_tick && (bus.cpu_wr_tick || bus.cpu_rd_tick))
                   || (bus.cpu_wr_tick && bus.cpu_rd_tick);

    // Reset gates the strobe so a write pending at reset never reaches VRAM.
    assign bus.vram_addr    = bus.dma_rd_tick ? bus.dma_addr : cpu_addr_reg;
    assign bus.vram_wr      = !bus.dma_rd_tick && (state == ARB_PEND_WR) && !reset;
    assign bus.vram_din     = wr_buf;
    assign bus.cpu_rd_data  = rd_buf;
    assign bus.cpu_busy     = busy;
    assign bus.cpu_overrun  = overrun;
    assign bus.cpu_wait_max = wait_max;

    always_ff @(posedge pxclk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            cpu_addr_reg <= '0;
            rd_buf       <= '0;
            wr_buf       <= '0;
            overrun      <= 1'b0;
            wait_ctr     <= '0;
            wait_max     <= '0;
        end else begin
            case (state)
                ARB_PEND_RD: begin
                    if (!bus.dma_rd_tick)
                        state <= ARB_RD_CAP;
                    else if (wait_ctr != '1)
                        wait_ctr <= wait_ctr + 1'b1;
                end
                ARB_RD_CAP: begin
                    rd_buf       <= bus.vram_dout;
                    cpu_addr_reg <= cpu_addr_reg + 1'b1;
                    state        <= ARB_IDLE;
                end
                ARB_PEND_WR: begin
                    if (!bus.dma_rd_tick) begin
                        rd_buf       <= wr_buf;
                        cpu_addr_reg <= cpu_addr_reg + 1'b1;
                        state        <= ARB_IDLE;
                    end else if (wait_ctr != '1) begin
                        wait_ctr <= wait_ctr + 1'b1;
                    end
                end
                default: ;
            endcase

            if (issue && (wait_ctr > wait_max))
                wait_max <= wait_ctr;

            // An address load is accepted even when busy and aborts the pending op.
            if (bus.cpu_addr_tick) begin
                cpu_addr_reg <= bus.cpu_addr;
                if (bus.cpu_addr_rd) begin
                    state    <= ARB_PEND_RD;
                    wait_ctr <= '0;
                end else begin
                    state <= ARB_IDLE;
                end
            end else if (!busy && bus.cpu_wr_tick) begin
                wr_buf   <= bus.cpu_wr_data;
                state    <= ARB_PEND_WR;
                wait_ctr <= '0;
            end else if (!busy && bus.cpu_rd_tick) begin
                state    <= ARB_PEND_RD;
                wait_ctr <= '0;
            end

            if (ovr_set)
                overrun <= 1'b1;
            else if (bus.cpu_overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Directed bench for vdp_vram_arb with a registered-read VRAM model.
module tb_vdp_vram_arb;
    import vdp_pkg::*;

    logic pxclk = 1'b0;
    logic reset = 1'b1;
    always #20 pxclk = ~pxclk;

    vdp_vram_arb_if #(.ADDR_W(14), .WAIT_W(8)) bus ();

    vdp_vram_arb #(.ADDR_W(14), .WAIT_W(8)) dut (
        .pxclk (pxclk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:16383];

    always @(posedge pxclk) begin
        if (bus.vram_wr) mem[bus.vram_addr] <= bus.vram_din;
        bus.vram_dout <= mem[bus.vram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic at, input logic ar, input logic [13:0] ca,
                         input logic wt, input logic [7:0] wd, input logic rt, input logic oc);
        bus.cpu_addr_tick   = at;
        bus.cpu_addr_rd     = ar;
        bus.cpu_addr        = ca;
        bus.cpu_wr_tick     = wt;
        bus.cpu_wr_data     = wd;
        bus.cpu_rd_tick     = rt;
        bus.cpu_overrun_clr = oc;
    endtask

    typedef struct {
        logic        at, ar;
        logic [13:0] ca;
        logic        wt;
        logic [7:0]  wd;
        logic        rt, oc;
        logic        e_busy, e_wr;
        logic [13:0] e_addr;
        logic [7:0]  e_rd, e_din;
        logic        e_ovr;
    } vec_t;

    vec_t vec [23];

    initial begin
        int n;
        int cyc;
        int collide;
        int follow_bad;
        string nm;

        for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
        mem[14'h1234] <= 8'hA5;
        mem[14'h0100] <= 8'h3C;
        mem[14'h0200] <= 8'hC3;

        // at ar  ca         wt    wd     rt    oc  | busy  wr    addr       rd     din    ovr
        vec[0]  = '{1'b1,1'b1,14'h1234,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0000,8'h00,8'h00,1'b0};
        vec[1]  = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,14'h1234,8'h00,8'h00,1'b0};
        vec[2]  = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,14'h1234,8'h00,8'h00,1'b0};
        vec[3]  = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h1235,8'hA5,8'h00,1'b0};
        vec[4]  = '{1'b1,1'b0,14'h3FFF,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h1235,8'hA5,8'h00,1'b0};
        vec[5]  = '{1'b0,1'b0,14'h0000,1'b1,8'h5A,1'b0,1'b0, 1'b0,1'b0,14'h3FFF,8'hA5,8'h00,1'b0};
        vec[6]  = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,14'h3FFF,8'hA5,8'h5A,1'b0};
        vec[7]  = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0000,8'h5A,8'h5A,1'b0};
        vec[8]  = '{1'b1,1'b1,14'h0100,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0000,8'h5A,8'h5A,1'b0};
        vec[9]  = '{1'b0,1'b0,14'h0000,1'b1,8'h77,1'b0,1'b0, 1'b1,1'b0,14'h0100,8'h5A,8'h5A,1'b0};
        vec[10] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,14'h0100,8'h5A,8'h5A,1'b1};
        vec[11] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0101,8'h3C,8'h5A,1'b1};
        vec[12] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0101,8'h3C,8'h5A,1'b1};
        vec[13] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,14'h0101,8'h3C,8'h5A,1'b1};
        vec[14] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0101,8'h3C,8'h5A,1'b0};
        vec[15] = '{1'b1,1'b0,14'h0200,1'b1,8'h99,1'b0,1'b0, 1'b0,1'b0,14'h0101,8'h3C,8'h5A,1'b0};
        vec[16] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0200,8'h3C,8'h5A,1'b1};
        vec[17] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,14'h0200,8'h3C,8'h5A,1'b1};
        vec[18] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0200,8'h3C,8'h5A,1'b0};
        vec[19] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b1,1'b0, 1'b0,1'b0,14'h0200,8'h3C,8'h5A,1'b0};
        vec[20] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,14'h0200,8'h3C,8'h5A,1'b0};
        vec[21] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,14'h0200,8'h3C,8'h5A,1'b0};
        vec[22] = '{1'b0,1'b0,14'h0000,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,14'h0201,8'hC3,8'h5A,1'b0};

        drive(1'b0, 1'b0, 14'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        bus.dma_rd_tick = 1'b0;
        bus.dma_addr    = 14'h0;

        // Reset values
        repeat (2) @(posedge pxclk);
        @(negedge pxclk);
        chk("rst_busy",    32'(bus.cpu_busy),     32'h0);
        chk("rst_overrun", 32'(bus.cpu_overrun),  32'h0);
        chk("rst_waitmax", 32'(bus.cpu_wait_max), 32'h0);
        chk("rst_vram_wr", 32'(bus.vram_wr),      32'h0);
        chk("rst_rd_data", 32'(bus.cpu_rd_data),  32'h0);
        chk("rst_din",     32'(bus.vram_din),     32'h0);
        chk("rst_addr",    32'(bus.vram_addr),    32'h0);
        @(posedge pxclk); #1;
        reset = 1'b0;

        // Table: read-ahead, write with wrap, overrun, tick priority, refill read
        for (int i = 0; i < 23; i++) begin
            drive(vec[i].at, vec[i].ar, vec[i].ca, vec[i].wt, vec[i].wd, vec[i].rt, vec[i].oc);
            @(negedge pxclk);
            nm = $sformatf("v%0d", i);
            chk({nm, "_busy"}, 32'(bus.cpu_busy),    32'(vec[i].e_busy));
            chk({nm, "_wr"},   32'(bus.vram_wr),     32'(vec[i].e_wr));
            chk({nm, "_addr"}, 32'(bus.vram_addr),   32'(vec[i].e_addr));
            chk({nm, "_rd"},   32'(bus.cpu_rd_data), 32'(vec[i].e_rd));
            chk({nm, "_din"},  32'(bus.vram_din),    32'(vec[i].e_din));
            chk({nm, "_ovr"},  32'(bus.cpu_overrun), 32'(vec[i].e_ovr));
            @(posedge pxclk); #1;
        end
        drive(1'b0, 1'b0, 14'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        chk("mem_3fff", 32'(mem[14'h3FFF]), 32'h5A);
        chk("waitmax_nodma", 32'(bus.cpu_wait_max), 32'h0);

        // DMA held 5 cycles over a pending write
        drive(1'b0, 1'b0, 14'h0, 1'b1, 8'hE1, 1'b0, 1'b0);
        @(posedge pxclk); #1;
        drive(1'b0, 1'b0, 14'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        bus.dma_rd_tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.dma_addr = 14'h2000 + 14'(i);
            @(negedge pxclk);
            chk($sformatf("dma%0d_addr", i), 32'(bus.vram_addr), 32'h2000 + i);
            chk($sformatf("dma%0d_wr", i),   32'(bus.vram_wr),   32'h0);
            chk($sformatf("dma%0d_busy", i), 32'(bus.cpu_busy),  32'h1);
            @(posedge pxclk); #1;
        end
        bus.dma_rd_tick = 1'b0;
        @(negedge pxclk);
        chk("dmawr_issue", 32'(bus.vram_wr),   32'h1);
        chk("dmawr_addr",  32'(bus.vram_addr), 32'h0201);
        chk("dmawr_din",   32'(bus.vram_din),  32'hE1);
        @(posedge pxclk); #1;
        @(negedge pxclk);
        chk("dmawr_waitmax", 32'(bus.cpu_wait_max), 32'h5);
        chk("dmawr_busy",    32'(bus.cpu_busy),     32'h0);
        chk("dmawr_rd",      32'(bus.cpu_rd_data),  32'hE1);
        chk("dmawr_mem",     32'(mem[14'h0201]),    32'hE1);
        @(posedge pxclk); #1;

        // Ring: DMA in slots 0,2,3 of 8, back-to-back CPU writes from 0x0800
        drive(1'b1, 1'b0, 14'h0800, 1'b0, 8'h0, 1'b0, 1'b0);
        @(posedge pxclk); #1;
        n = 0; collide = 0; follow_bad = 0; cyc = 0;
        while ((n < 16 || bus.cpu_busy) && cyc < 200) begin
            bus.dma_rd_tick = ((cyc % 8) == 0) || ((cyc % 8) == 2) || ((cyc % 8) == 3);
            bus.dma_addr    = 14'h3000 + 14'(cyc);
            if (!bus.cpu_busy && n < 16) begin
                drive(1'b0, 1'b0, 14'h0, 1'b1, 8'h40 + 8'(n), 1'b0, 1'b0);
                n++;
            end else begin
                drive(1'b0, 1'b0, 14'h0, 1'b0, 8'h0, 1'b0, 1'b0);
            end
            @(negedge pxclk);
            if (bus.dma_rd_tick && bus.vram_wr) collide++;
            if (bus.dma_rd_tick && bus.vram_addr != bus.dma_addr) follow_bad++;
            @(posedge pxclk); #1;
            cyc++;
        end
        drive(1'b0, 1'b0, 14'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        bus.dma_rd_tick = 1'b0;
        chk("ring_timeout",  32'(cyc < 200),          32'h1);
        chk("ring_collide",  32'(collide),            32'h0);
        chk("ring_dma_addr", 32'(follow_bad),         32'h0);
        chk("ring_overrun",  32'(bus.cpu_overrun),    32'h0);
        for (int k = 0; k < 16; k++)
            chk($sformatf("ring_mem%0d", k), 32'(mem[14'h0800 + 14'(k)]), 32'h40 + k);

        // Reset while a write is pending (overrun set by a wr+rd collision first)
        drive(1'b0, 1'b0, 14'h0, 1'b1, 8'hBB, 1'b1, 1'b0);
        @(posedge pxclk); #1;
        drive(1'b0, 1'b0, 14'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge pxclk);
        chk("rstwr_busy",    32'(bus.cpu_busy),    32'h1);
        chk("rstwr_overrun", 32'(bus.cpu_overrun), 32'h1);
        chk("rstwr_no_wr",   32'(bus.vram_wr),     32'h0);
        @(posedge pxclk); #1;
        reset = 1'b0;
        @(negedge pxclk);
        chk("rstwr_busy0",    32'(bus.cpu_busy),     32'h0);
        chk("rstwr_ovr0",     32'(bus.cpu_overrun),  32'h0);
        chk("rstwr_waitmax0", 32'(bus.cpu_wait_max), 32'h0);
        chk("rstwr_rd0",      32'(bus.cpu_rd_data),  32'h0);
        chk("rstwr_din0",     32'(bus.vram_din),     32'h0);
        chk("rstwr_addr0",    32'(bus.vram_addr),    32'h0);
        chk("rstwr_wr0",      32'(bus.vram_wr),      32'h0);
        @(posedge pxclk); #1;
        chk("rstwr_mem", 32'(mem[14'h0810]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
